// File: rtl/falafel_pkg.sv
// Shared types for the falafel memory responder: data width, word type and
// the request-op decode used by the responder.
package falafel_pkg;

  localparam int DATA_W   = 32;
  localparam int BYTE_LSB = $clog2(DATA_W / 8);

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_CAS   = 2'd2
  } op_e;

  // is_cas only matters for writes; a read with is_cas set is still a read.
  function automatic op_e decode_op(input logic is_write, input logic is_cas);
    if (!is_write) begin
      return OP_READ;
    end
    return is_cas ? OP_CAS : OP_WRITE;
  endfunction

endpackage

// File: rtl/falafel_fifo.sv
// Small synchronous FIFO with a combinational head read; holds responses
// until the requester takes them.
module falafel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = buf_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      buf_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/falafel_mem_responder.sv
// Behavioural memory responder for falafel: atomic read/write/CAS on a flat
// word store, fixed-latency response pipe and a credit-guarded output FIFO.
module falafel_mem_responder
  import falafel_pkg::*;
#(
  parameter int MEM_WORDS       = 256,
  parameter int LATENCY         = 2,
  parameter int RESP_FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req_val_i,
  output logic              mem_req_rdy_o,
  input  logic              mem_req_is_write_i,
  input  logic              mem_req_is_cas_i,
  input  logic [DATA_W-1:0] mem_req_addr_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  input  logic [DATA_W-1:0] mem_req_cas_exp_i,
  output logic              mem_resp_val_o,
  input  logic              mem_resp_rdy_i,
  output logic [DATA_W-1:0] mem_resp_data_o,
  input  logic              stall_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);

  word_t            store_q [MEM_WORDS];
  logic [IDX_W-1:0] word_idx;
  op_e              req_op;
  word_t            old_word;
  logic             accept;
  logic             responds;
  logic             store_we;
  logic             resp_pop;

  logic             dly_val_q  [LATENCY];
  word_t            dly_data_q [LATENCY];

  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  logic             fifo_empty;
  word_t            fifo_head;
  logic             unused_fifo_full;
  logic             unused_addr_bits;

  // Byte-offset bits and bits above the store size are dropped, so addresses wrap.
  assign word_idx         = mem_req_addr_i[BYTE_LSB +: IDX_W];
  assign unused_addr_bits = ^{mem_req_addr_i[BYTE_LSB-1:0],
                              mem_req_addr_i[DATA_W-1:BYTE_LSB+IDX_W]};

  // Credits cover the pipe plus the FIFO, so a full pipe can always drain.
  assign mem_req_rdy_o = !stall_i && !rst_i && (outstanding_q < CNT_W'(RESP_FIFO_DEPTH));
  assign accept        = mem_req_val_i && mem_req_rdy_o;

  always_comb begin
    req_op   = decode_op(mem_req_is_write_i, mem_req_is_cas_i);
    old_word = store_q[word_idx];
    responds = 1'b0;
    store_we = 1'b0;
    if (accept) begin
      case (req_op)
        OP_READ:  responds = 1'b1;
        OP_WRITE: store_we = 1'b1;
        OP_CAS: begin
          responds = 1'b1;
          store_we = (old_word == mem_req_cas_exp_i);
        end
        default: begin
          responds = 1'b0;
          store_we = 1'b0;
        end
      endcase
    end
  end

  // Store is deliberately left out of reset so committed data survives it.
  always_ff @(posedge clk_i) begin
    if (store_we) begin
      store_q[word_idx] <= mem_req_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            dly_val_q[0] <= 1'b0;
          end else begin
            dly_val_q[0] <= responds;
          end
          dly_data_q[0] <= old_word;
        end
      end else begin : g_tail
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            dly_val_q[gi] <= 1'b0;
          end else begin
            dly_val_q[gi] <= dly_val_q[gi-1];
          end
          dly_data_q[gi] <= dly_data_q[gi-1];
        end
      end
    end
  endgenerate

  assign mem_resp_val_o  = !fifo_empty && !rst_i;
  assign mem_resp_data_o = fifo_head;
  assign resp_pop        = mem_resp_val_o && mem_resp_rdy_i;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({responds, resp_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  falafel_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (!rst_i),
    .push_i      (dly_val_q[LATENCY-1]),
    .push_data_i (dly_data_q[LATENCY-1]),
    .pop_i       (resp_pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (unused_fifo_full)
  );

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Scoreboard bench for falafel_mem_responder: a reference word model predicts
// every response at accept time; a monitor collects responses as they pop.
module tb_falafel_mem_responder;
  import falafel_pkg::*;

  localparam int MEM_WORDS = 256;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 4;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rx_t;

  logic        clk;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_is_write;
  logic        req_is_cas;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] req_exp;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_data;
  logic        stall;

  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;

  logic [31:0] model [MEM_WORDS];
  logic [31:0] exp_q [$];
  int          acc_q [$];
  rx_t         rx_q  [$];

  falafel_mem_responder #(
    .MEM_WORDS       (MEM_WORDS),
    .LATENCY         (LATENCY),
    .RESP_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_req_val_i      (req_val),
    .mem_req_rdy_o      (req_rdy),
    .mem_req_is_write_i (req_is_write),
    .mem_req_is_cas_i   (req_is_cas),
    .mem_req_addr_i     (req_addr),
    .mem_req_data_i     (req_data),
    .mem_req_cas_exp_i  (req_exp),
    .mem_resp_val_o     (resp_val),
    .mem_resp_rdy_i     (resp_rdy),
    .mem_resp_data_o    (resp_data),
    .stall_i            (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_val && resp_rdy) begin
      rx_q.push_back('{resp_data, cyc});
      $display("[cyc %0d] resp data=%08h", cyc, resp_data);
    end
  end

  function automatic int widx(input logic [31:0] addr);
    return int'((addr >> 2) % MEM_WORDS);
  endfunction

  // Model update at the accept instant; responding ops queue their prediction.
  task automatic model_accept(input op_e op, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] expv);
    int i;
    i = widx(addr);
    case (op)
      OP_READ: begin
        exp_q.push_back(model[i]);
        acc_q.push_back(cyc);
      end
      OP_WRITE: model[i] = data;
      default: begin
        exp_q.push_back(model[i]);
        acc_q.push_back(cyc);
        if (model[i] == expv) model[i] = data;
      end
    endcase
    $display("[cyc %0d] accept op=%0d addr=%08h data=%08h exp=%08h", cyc, op, addr, data, expv);
  endtask

  task automatic drive(input op_e op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] expv);
    req_is_write = (op != OP_READ);
    req_is_cas   = (op == OP_CAS);
    req_addr     = addr;
    req_data     = data;
    req_exp      = expv;
  endtask

  // Entered and left at posedge+1; waits is the number of cycles spent unaccepted.
  task automatic issue(input op_e op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] expv, output int waits);
    bit ok;
    ok    = 0;
    waits = 0;
    drive(op, addr, data, expv);
    req_val = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_rdy) begin
        ok = 1;
        model_accept(op, addr, data, expv);
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    req_val = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL issue_timeout: request addr=%08h not accepted, required accept within 200 cycles", addr);
    end
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 100 && rx_q.size() < n; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    acc_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b1;
    req_val = 1'b1;
    drive(OP_WRITE, 32'h0, 32'hFFFF_FFFF, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (req_rdy !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_rdy: got %b, required 0", req_rdy);
      end
      compared++;
      if (resp_val !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_resp_val: got %b, required 0", resp_val);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_val = 1'b0;
    issue(OP_WRITE, 32'h300, 32'h5555, 32'h0, w);
    compared++;
    if (w != 0) begin
      mismatched++;
      $display("FAIL first_accept: waited %0d cycles, required 0", w);
    end
  endtask

  task automatic test_write_read();
    int w;
    int a;
    logic [31:0] e;
    rx_t r;
    clear_q();
    issue(OP_WRITE, 32'h40, 32'h1234, 32'h0, w);
    issue(OP_READ,  32'h40, 32'h0,    32'h0, w);
    wait_rx(1);
    compared++;
    if (rx_q.size() != 1) begin
      mismatched++;
      $display("FAIL wr_rd_count: got %0d responses, required 1", rx_q.size());
    end
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      a = acc_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL wr_rd_data: got %08h, required %08h", r.data, e);
      end
      compared++;
      if (r.cyc - a != LATENCY + 1) begin
        mismatched++;
        $display("FAIL wr_rd_latency: got %0d cycles, required %0d", r.cyc - a, LATENCY + 1);
      end
    end
  endtask

  task automatic test_cas();
    int w;
    int a;
    int n;
    logic [31:0] e;
    rx_t r;
    clear_q();
    issue(OP_WRITE, 32'h80, 32'd5, 32'd0, w);
    issue(OP_CAS,   32'h80, 32'd9, 32'd5, w);
    issue(OP_CAS,   32'h80, 32'd7, 32'd5, w);
    issue(OP_READ,  32'h80, 32'd0, 32'd0, w);
    n = exp_q.size();
    wait_rx(n);
    compared++;
    if (rx_q.size() != 3) begin
      mismatched++;
      $display("FAIL cas_count: got %0d responses, required 3", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      a = acc_q.pop_front();
      compared++;
      if (r.data !== e || r.cyc - a != LATENCY + 1) begin
        mismatched++;
        $display("FAIL cas_resp: got %08h after %0d cycles, required %08h after %0d",
                 r.data, r.cyc - a, e, LATENCY + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    int acc;
    logic [31:0] e;
    rx_t r;
    for (int k = 0; k < 6; k++) issue(OP_WRITE, 32'h100 + 4 * k, 32'h1000 + 32'h11 * k, 32'h0, w);
    clear_q();
    resp_rdy = 1'b0;
    acc = 0;
    req_val = 1'b1;
    drive(OP_READ, 32'h100, 32'h0, 32'h0);
    for (int c = 0; c < 12 && acc < 6; c++) begin
      @(negedge clk);
      if (req_rdy) begin
        model_accept(OP_READ, req_addr, 32'h0, 32'h0);
        acc++;
      end
      @(posedge clk);
      #1;
      req_addr = 32'h100 + 4 * acc;
    end
    @(negedge clk);
    compared++;
    if (acc != DEPTH) begin
      mismatched++;
      $display("FAIL bp_accepted: got %0d, required %0d", acc, DEPTH);
    end
    compared++;
    if (req_rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_rdy: got %b, required 0", req_rdy);
    end
    compared++;
    if (resp_val !== 1'b1 || exp_q.size() == 0 || resp_data !== exp_q[0]) begin
      mismatched++;
      $display("FAIL bp_hold: val=%b data=%08h, required val=1 data=head of scoreboard", resp_val, resp_data);
    end
    @(posedge clk);
    #1;
    resp_rdy = 1'b1;
    for (int c = 0; c < 40 && acc < 6; c++) begin
      @(negedge clk);
      if (req_rdy) begin
        model_accept(OP_READ, req_addr, 32'h0, 32'h0);
        acc++;
      end
      @(posedge clk);
      #1;
      req_addr = 32'h100 + 4 * acc;
    end
    req_val = 1'b0;
    compared++;
    if (acc != 6) begin
      mismatched++;
      $display("FAIL bp_total: got %0d accepted, required 6", acc);
    end
    wait_rx(6);
    compared++;
    if (rx_q.size() != 6) begin
      mismatched++;
      $display("FAIL bp_count: got %0d responses, required 6", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL bp_order: got %08h, required %08h", r.data, e);
      end
    end
  endtask

  task automatic test_wrap();
    int w;
    logic [31:0] e;
    rx_t r;
    clear_q();
    issue(OP_WRITE, 32'h0, 32'hAA, 32'h0, w);
    issue(OP_READ, MEM_WORDS * 4, 32'h0, 32'h0, w);
    wait_rx(1);
    compared++;
    if (rx_q.size() != 1 || exp_q.size() != 1) begin
      mismatched++;
      $display("FAIL wrap_count: got %0d responses, required 1", rx_q.size());
    end else begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL wrap_data: got %08h, required %08h", r.data, e);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int w;
    logic [31:0] e;
    rx_t r;
    issue(OP_WRITE, 32'h10, 32'h77, 32'h0, w);
    resp_rdy = 1'b0;
    issue(OP_READ, 32'h10, 32'h0, 32'h0, w);
    issue(OP_READ, 32'h40, 32'h0, 32'h0, w);
    issue(OP_READ, 32'h80, 32'h0, 32'h0, w);
    clear_q();
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (resp_val !== 1'b0 || req_rdy !== 1'b0) begin
      mismatched++;
      $display("FAIL midrst_outputs: val=%b rdy=%b, required both 0", resp_val, req_rdy);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_rdy = 1'b1;
    repeat (12) @(negedge clk);
    compared++;
    if (rx_q.size() != 0) begin
      mismatched++;
      $display("FAIL midrst_flush: got %0d responses, required 0", rx_q.size());
    end
    @(posedge clk);
    #1;
    clear_q();
    issue(OP_READ, 32'h10, 32'h0, 32'h0, w);
    issue(OP_READ, 32'h12, 32'h0, 32'h0, w);
    wait_rx(2);
    compared++;
    if (rx_q.size() != 2) begin
      mismatched++;
      $display("FAIL midrst_count: got %0d responses, required 2", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL midrst_persist: got %08h, required %08h", r.data, e);
      end
    end
  endtask

  task automatic test_stall();
    int w;
    logic [31:0] e;
    rx_t r;
    clear_q();
    stall = 1'b1;
    req_val = 1'b1;
    drive(OP_WRITE, 32'h40, 32'hDEAD, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compared++;
      if (req_rdy !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_rdy: got %b, required 0", req_rdy);
      end
      @(posedge clk);
      #1;
    end
    req_val = 1'b0;
    stall = 1'b0;
    issue(OP_READ, 32'h40, 32'h0, 32'h0, w);
    wait_rx(1);
    if (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL stall_store: got %08h, required %08h", r.data, e);
      end
    end else begin
      compared++;
      mismatched++;
      $display("FAIL stall_count: got %0d responses, required 1", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int w;
    int n;
    bit done;
    logic [31:0] e;
    rx_t r;
    op_e op;
    clear_q();
    done = 0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          case ($urandom_range(0, 2))
            0:       op = OP_READ;
            1:       op = OP_WRITE;
            default: op = OP_CAS;
          endcase
          issue(op, 32'h200 + $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          resp_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    resp_rdy = 1'b1;
    n = exp_q.size();
    wait_rx(n);
    compared++;
    if (rx_q.size() != n) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d responses, required %0d", rx_q.size(), n);
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      r = rx_q.pop_front();
      e = exp_q.pop_front();
      compared++;
      if (r.data !== e) begin
        mismatched++;
        $display("FAIL b2b_data: got %08h, required %08h", r.data, e);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    req_val = 1'b0;
    req_is_write = 1'b0;
    req_is_cas = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_exp = '0;
    resp_rdy = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) model[i] = '0;
    #1;
    test_reset();
    test_write_read();
    test_cas();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
